// File: rtl/sd_pkg.sv
// Shared constants, state encodings and frame builder for the SD SPI-mode
// initialisation sequencer.
package sd_pkg;

   localparam logic [5:0] CMD_GO_IDLE  = 6'd0;
   localparam logic [5:0] CMD_IF_COND  = 6'd8;
   localparam logic [5:0] CMD_SEND_OP  = 6'd41;
   localparam logic [5:0] CMD_APP      = 6'd55;
   localparam logic [5:0] CMD_READ_OCR = 6'd58;

   localparam logic [7:0] CRC_CMD0  = 8'h95;
   localparam logic [7:0] CRC_CMD8  = 8'h87;
   localparam logic [7:0] CRC_ACMD  = 8'h01;
   localparam logic [7:0] CRC_CMD58 = 8'hFD;

   localparam logic [31:0] ARG_IF_COND = 32'h0000_01AA;
   localparam logic [31:0] ARG_HCS     = 32'h4000_0000;

   localparam logic [2:0] ERR_NONE   = 3'd0;
   localparam logic [2:0] ERR_CMD0   = 3'd1;
   localparam logic [2:0] ERR_CMD8   = 3'd2;
   localparam logic [2:0] ERR_ACMD41 = 3'd3;
   localparam logic [2:0] ERR_CMD58  = 3'd4;
   localparam logic [2:0] ERR_CMD55  = 3'd5;

   typedef enum logic [3:0] {
      S_IDLE, S_DUMMY, S_CMD0, S_CMD8, S_C55, S_A41, S_CMD58, S_DONE, S_FAIL
   } seq_state_e;

   typedef enum logic [2:0] {
      X_IDLE, X_DUMMY, X_FRAME, X_POLL, X_TRAIL, X_GAP
   } xfer_state_e;

   function automatic logic [47:0] sd_frame(input logic [5:0] idx, input logic [31:0] arg,
                                            input logic [7:0] crc);
      return {2'b01, idx, arg, crc};
   endfunction

   function automatic logic [47:0] cmd_frame(input seq_state_e s);
      case (s)
         S_CMD0:  return sd_frame(CMD_GO_IDLE, 32'h0, CRC_CMD0);
         S_CMD8:  return sd_frame(CMD_IF_COND, ARG_IF_COND, CRC_CMD8);
         S_C55:   return sd_frame(CMD_APP, 32'h0, CRC_ACMD);
         S_A41:   return sd_frame(CMD_SEND_OP, ARG_HCS, CRC_ACMD);
         S_CMD58: return sd_frame(CMD_READ_OCR, 32'h0, CRC_CMD58);
         default: return '1;
      endcase
   endfunction

   function automatic logic [2:0] cmd_extra(input seq_state_e s);
      return (s == S_CMD8 || s == S_CMD58) ? 3'd4 : 3'd0;
   endfunction

endpackage

// File: rtl/sd_cmd_xfer.sv
// One SD command transfer over the byte-level SPI master: frame, R1 poll,
// trailing bytes, gap byte. Also emits the cs_n-high dummy-clock preamble.
module sd_cmd_xfer
   import sd_pkg::*;
#(
   parameter int INIT_BYTES   = 10,
   parameter int RESP_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        go_i,
   input  logic        dummy_i,
   input  logic [47:0] frame_i,
   input  logic [2:0]  extra_i,
   output logic        done_o,
   output logic        tmo_o,
   output logic [7:0]  r1_o,
   output logic [31:0] word_o,
   output logic        spi_req_o,
   output logic [7:0]  spi_tx_o,
   input  logic        spi_ack_i,
   input  logic [7:0]  spi_rx_i,
   output logic        cs_n_o
);

   xfer_state_e st_q;
   logic [7:0]  cnt_q;
   logic [39:0] frame_q;
   logic [2:0]  extra_q;
   logic        tmo_q, req_q, pend_q, cs_n_q, done_q, tmo_p_q;
   logic [7:0]  tx_q, r1_q;
   logic [31:0] word_q;
   logic        ack_ok;

   // pend_q makes stray acks (including one left over from before a reset) harmless
   assign ack_ok = spi_ack_i && pend_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q    <= X_IDLE;
         cnt_q   <= '0;
         frame_q <= '0;
         extra_q <= '0;
         tmo_q   <= 1'b0;
         req_q   <= 1'b0;
         pend_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         done_q  <= 1'b0;
         tmo_p_q <= 1'b0;
         tx_q    <= 8'hFF;
         r1_q    <= 8'hFF;
         word_q  <= '0;
      end else begin
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         tmo_p_q <= 1'b0;
         if (ack_ok) pend_q <= 1'b0;
         case (st_q)
            X_IDLE: if (go_i) begin
               cnt_q   <= '0;
               tmo_q   <= 1'b0;
               word_q  <= '0;
               extra_q <= extra_i;
               frame_q <= frame_i[39:0];
               tx_q    <= dummy_i ? 8'hFF : frame_i[47:40];
               cs_n_q  <= dummy_i;
               st_q    <= dummy_i ? X_DUMMY : X_FRAME;
               req_q   <= 1'b1;
               pend_q  <= 1'b1;
            end
            X_DUMMY: if (ack_ok) begin
               if (cnt_q == 8'(INIT_BYTES - 1)) begin
                  st_q   <= X_IDLE;
                  done_q <= 1'b1;
               end else begin
                  cnt_q  <= cnt_q + 8'd1;
                  req_q  <= 1'b1;
                  pend_q <= 1'b1;
               end
            end
            X_FRAME: if (ack_ok) begin
               if (cnt_q == 8'd5) begin
                  st_q  <= X_POLL;
                  cnt_q <= '0;
                  tx_q  <= 8'hFF;
               end else begin
                  cnt_q   <= cnt_q + 8'd1;
                  tx_q    <= frame_q[39:32];
                  frame_q <= {frame_q[31:0], 8'hFF};
               end
               req_q  <= 1'b1;
               pend_q <= 1'b1;
            end
            X_POLL: if (ack_ok) begin
               if (!spi_rx_i[7]) begin
                  r1_q  <= spi_rx_i;
                  cnt_q <= '0;
                  if (extra_q == 3'd0) begin
                     st_q   <= X_GAP;
                     cs_n_q <= 1'b1;
                  end else begin
                     st_q <= X_TRAIL;
                  end
               end else if (cnt_q == 8'(RESP_TIMEOUT - 1)) begin
                  tmo_q  <= 1'b1;
                  st_q   <= X_GAP;
                  cs_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
               tx_q   <= 8'hFF;
               req_q  <= 1'b1;
               pend_q <= 1'b1;
            end
            X_TRAIL: if (ack_ok) begin
               word_q <= {word_q[23:0], spi_rx_i};
               if (cnt_q == {5'd0, extra_q} - 8'd1) begin
                  st_q   <= X_GAP;
                  cs_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
               req_q  <= 1'b1;
               pend_q <= 1'b1;
            end
            X_GAP: if (ack_ok) begin
               st_q    <= X_IDLE;
               done_q  <= !tmo_q;
               tmo_p_q <= tmo_q;
            end
            default: st_q <= X_IDLE;
         endcase
      end
   end

   assign done_o    = done_q;
   assign tmo_o     = tmo_p_q;
   assign r1_o      = r1_q;
   assign word_o    = word_q;
   assign spi_req_o = req_q;
   assign spi_tx_o  = tx_q;
   assign cs_n_o    = cs_n_q;

endmodule

// File: rtl/sd_spi_seq.sv
// SD-card SPI-mode power-up sequencer: dummy clocks, CMD0, CMD8,
// CMD55/ACMD41 loop, CMD58; reports done/ccs or an error code.
module sd_spi_seq
   import sd_pkg::*;
#(
   parameter int INIT_BYTES     = 10,
   parameter int RESP_TIMEOUT   = 8,
   parameter int ACMD41_RETRIES = 1000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [2:0] err_code,
   output logic       ccs,
   output logic       slow_clk,
   output logic       spi_req,
   output logic [7:0] spi_tx,
   input  logic       spi_ack,
   input  logic [7:0] spi_rx,
   output logic       cs_n
);

   seq_state_e  st_q;
   logic        go_q, busy_q, done_q, error_q, ccs_q, slow_q;
   logic [2:0]  err_q;
   logic [15:0] retry_q, retry_d;
   logic        x_done, x_tmo, x_dummy;
   logic [7:0]  x_r1;
   logic [31:0] x_word;
   logic [47:0] x_frame;
   logic [2:0]  x_extra;
   logic        cmd8_ok, unused_word;

   assign retry_d = retry_q + 16'd1;
   // frame/extra are decoded from the state register, which is stable when go_q fires
   assign x_dummy = (st_q == S_DUMMY);
   assign x_frame = cmd_frame(st_q);
   assign x_extra = cmd_extra(st_q);
   assign cmd8_ok = (x_r1 == 8'h01) && (x_word[11:8] == 4'h1) && (x_word[7:0] == 8'hAA);
   assign unused_word = ^{x_word[31], x_word[29:12]};

   sd_cmd_xfer #(
      .INIT_BYTES  (INIT_BYTES),
      .RESP_TIMEOUT(RESP_TIMEOUT)
   ) u_xfer (
      .clk      (clk),
      .resetn   (resetn),
      .go_i     (go_q),
      .dummy_i  (x_dummy),
      .frame_i  (x_frame),
      .extra_i  (x_extra),
      .done_o   (x_done),
      .tmo_o    (x_tmo),
      .r1_o     (x_r1),
      .word_o   (x_word),
      .spi_req_o(spi_req),
      .spi_tx_o (spi_tx),
      .spi_ack_i(spi_ack),
      .spi_rx_i (spi_rx),
      .cs_n_o   (cs_n)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q    <= S_IDLE;
         go_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         err_q   <= ERR_NONE;
         ccs_q   <= 1'b0;
         slow_q  <= 1'b1;
         retry_q <= '0;
      end else begin
         go_q <= 1'b0;
         case (st_q)
            S_IDLE, S_DONE, S_FAIL: if (start) begin
               st_q    <= S_DUMMY;
               go_q    <= 1'b1;
               busy_q  <= 1'b1;
               done_q  <= 1'b0;
               error_q <= 1'b0;
               err_q   <= ERR_NONE;
               ccs_q   <= 1'b0;
               slow_q  <= 1'b1;
               retry_q <= '0;
            end
            S_DUMMY: if (x_done) begin
               st_q <= S_CMD0;
               go_q <= 1'b1;
            end
            S_CMD0: if (x_done && x_r1 == 8'h01) begin
               st_q <= S_CMD8;
               go_q <= 1'b1;
            end else if (x_done || x_tmo) begin
               st_q <= S_FAIL; busy_q <= 1'b0; error_q <= 1'b1; err_q <= ERR_CMD0;
            end
            S_CMD8: if (x_done && cmd8_ok) begin
               st_q <= S_C55;
               go_q <= 1'b1;
            end else if (x_done || x_tmo) begin
               st_q <= S_FAIL; busy_q <= 1'b0; error_q <= 1'b1; err_q <= ERR_CMD8;
            end
            S_C55: if (x_done) begin
               st_q <= S_A41;
               go_q <= 1'b1;
            end else if (x_tmo) begin
               st_q <= S_FAIL; busy_q <= 1'b0; error_q <= 1'b1; err_q <= ERR_CMD55;
            end
            S_A41: if (x_done && x_r1 == 8'h00) begin
               st_q <= S_CMD58;
               go_q <= 1'b1;
            end else if (x_done && x_r1 == 8'h01 && retry_d < 16'(ACMD41_RETRIES)) begin
               retry_q <= retry_d;
               st_q    <= S_C55;
               go_q    <= 1'b1;
            end else if (x_done || x_tmo) begin
               st_q <= S_FAIL; busy_q <= 1'b0; error_q <= 1'b1; err_q <= ERR_ACMD41;
            end
            S_CMD58: if (x_done && x_r1 == 8'h00) begin
               st_q   <= S_DONE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               slow_q <= 1'b0;
               ccs_q  <= x_word[30];
            end else if (x_done || x_tmo) begin
               st_q <= S_FAIL; busy_q <= 1'b0; error_q <= 1'b1; err_q <= ERR_CMD58;
            end
            default: st_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign err_code = err_q;
   assign ccs      = ccs_q;
   assign slow_clk = slow_q;

endmodule

// File: tb/tb_sd_spi_seq.sv
// Randomized bench for sd_spi_seq: an SD card model answers the byte stream
// and a command-level model predicts the frame list and final status.
module tb_sd_spi_seq;
   localparam int INIT_BYTES = 10, RESP_TIMEOUT = 8, RETRIES = 4;

   logic clk = 1'b0, resetn = 1'b0, start = 1'b0, spi_ack = 1'b0;
   logic [7:0] spi_rx = 8'hFF;
   logic busy, done, error, ccs, slow_clk, spi_req, cs_n;
   logic [2:0] err_code;
   logic [7:0] spi_tx;

   always #5 clk = ~clk;

   sd_spi_seq #(.INIT_BYTES(INIT_BYTES), .RESP_TIMEOUT(RESP_TIMEOUT), .ACMD41_RETRIES(RETRIES)) dut (
      .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .error(error),
      .err_code(err_code), .ccs(ccs), .slow_clk(slow_clk), .spi_req(spi_req), .spi_tx(spi_tx),
      .spi_ack(spi_ack), .spi_rx(spi_rx), .cs_n(cs_n));

   int total = 0, bad = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // card configuration
   int mute_cmd = -1, a41_ones = 0, a41_seen = 0;
   logic [7:0] echo = 8'hAA;
   logic [31:0] ocr = 32'hC0FF8000;
   // card/link state
   int fc = 0, ndummy = 0, ngap = 0, viol = 0, nreq = 0, lat_cnt = 0, force_lat = -1;
   logic [47:0] fr = '0;
   logic [7:0] rq[$];
   logic [47:0] frames[$];
   int exp_cmds[$];
   logic pend = 1'b0, stale = 1'b0, pcs = 1'b1;
   logic [7:0] ptx = 8'hFF;

   task automatic card_resp(input logic [47:0] f);
      int cmd = int'(f[45:40]);
      if (cmd == mute_cmd) return;
      repeat ($urandom_range(0, RESP_TIMEOUT - 1)) rq.push_back(8'h80 | 8'($urandom));
      case (cmd)
         0:  rq.push_back(8'h01);
         8:  begin rq.push_back(8'h01); rq.push_back(8'h00); rq.push_back(8'h00);
                   rq.push_back(8'h01); rq.push_back(echo); end
         55: rq.push_back(8'h01);
         41: begin rq.push_back(a41_seen < a41_ones ? 8'h01 : 8'h00); a41_seen++; end
         58: begin rq.push_back(8'h00);
                   for (int i = 3; i >= 0; i--) rq.push_back(ocr[i*8 +: 8]); end
         default: ;
      endcase
   endtask

   task automatic card_xchg(input logic [7:0] tx, input logic cs, output logic [7:0] rx);
      rx = 8'hFF;
      if (cs) begin
         fc = 0;
         rq.delete();
         if (frames.size() == 0) ndummy++; else ngap++;
      end else if (fc < 6) begin
         fr = {fr[39:0], tx};
         fc++;
         if (fc == 6) begin frames.push_back(fr); card_resp(fr); end
      end else if (rq.size() > 0) begin
         rx = rq.pop_front();
      end
   endtask

   // SPI master + card: one outstanding byte, random ack latency
   initial begin
      forever begin
         @(negedge clk);
         spi_ack = 1'b0;
         if (spi_req === 1'b1) begin
            if (pend) viol++;
            nreq++;
            pend = 1'b1; ptx = spi_tx; pcs = cs_n;
            lat_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
         end
         if (pend) begin
            if (lat_cnt == 0) begin
               if (!stale && spi_tx !== ptx) viol++;
               card_xchg(ptx, pcs, spi_rx);
               spi_ack = 1'b1; pend = 1'b0; stale = 1'b0;
            end else lat_cnt--;
         end
      end
   end

   function automatic logic [47:0] ref_frame(input int c);
      case (c)
         0:  return 48'h40_00_00_00_00_95;
         8:  return 48'h48_00_00_01_AA_87;
         55: return 48'h77_00_00_00_00_01;
         41: return 48'h69_40_00_00_00_01;
         58: return 48'h7A_00_00_00_00_FD;
         default: return '0;
      endcase
   endfunction

   // command-level expectation from the card configuration
   task automatic model(output logic ed, output logic [2:0] ec, output logic eccs);
      ed = 1'b0; ec = 3'd0; eccs = 1'b0;
      exp_cmds.delete();
      exp_cmds.push_back(0);
      if (mute_cmd == 0) begin ec = 3'd1; return; end
      exp_cmds.push_back(8);
      if (mute_cmd == 8 || echo != 8'hAA) begin ec = 3'd2; return; end
      for (int k = 0; k < RETRIES; k++) begin
         exp_cmds.push_back(55);
         if (mute_cmd == 55) begin ec = 3'd5; return; end
         exp_cmds.push_back(41);
         if (mute_cmd == 41) begin ec = 3'd3; return; end
         if (k >= a41_ones) begin
            exp_cmds.push_back(58);
            if (mute_cmd == 58) begin ec = 3'd4; return; end
            ed = 1'b1; eccs = ocr[30];
            return;
         end
      end
      ec = 3'd3;
   endtask

   task automatic run_case(input string tag, input int mute, input logic [7:0] ech, input int ones,
                           input logic [31:0] o, input bit mid_start);
      logic ed, eccs;
      logic [2:0] ec;
      int cyc, n;
      mute_cmd = mute; echo = ech; a41_ones = ones; ocr = o; a41_seen = 0;
      frames.delete(); rq.delete(); fc = 0; ndummy = 0; ngap = 0; viol = 0;
      model(ed, ec, eccs);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({tag, ".busy_on"}, busy, 1);
      chk({tag, ".done_clr"}, done, 0);
      chk({tag, ".err_clr"}, error, 0);
      cyc = 0;
      while (busy && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         start = (mid_start && cyc == 40);
      end
      start = 1'b0;
      chk({tag, ".finish"}, busy, 0);
      chk({tag, ".done"}, done, ed);
      chk({tag, ".error"}, error, !ed);
      chk({tag, ".err_code"}, err_code, ec);
      chk({tag, ".ccs"}, ccs, eccs);
      chk({tag, ".slow_clk"}, slow_clk, !ed);
      chk({tag, ".cs_n"}, cs_n, 1);
      chk({tag, ".dummy_bytes"}, ndummy, INIT_BYTES);
      chk({tag, ".n_frames"}, frames.size(), exp_cmds.size());
      n = (frames.size() < exp_cmds.size()) ? frames.size() : exp_cmds.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s.frame%0d", tag, i), frames[i], ref_frame(exp_cmds[i]));
      chk({tag, ".gaps"}, ngap, exp_cmds.size());
      chk({tag, ".handshake"}, viol, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, nr, r;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst.busy", busy, 0);        chk("rst.done", done, 0);
      chk("rst.error", error, 0);      chk("rst.err_code", err_code, 0);
      chk("rst.ccs", ccs, 0);          chk("rst.slow_clk", slow_clk, 1);
      chk("rst.spi_req", spi_req, 0);  chk("rst.spi_tx", spi_tx, 8'hFF);
      chk("rst.cs_n", cs_n, 1);

      run_case("basic", -1, 8'hAA, 2, 32'hC0FF8000, 0);
      run_case("mute", 0, 8'hAA, 0, 32'hC0FF8000, 0);
      run_case("echo", -1, 8'hA5, 0, 32'hC0FF8000, 0);
      run_case("a41max", -1, 8'hAA, 1000, 32'hC0FF8000, 0);

      // asynchronous reset in the middle of the CMD8 frame
      mute_cmd = -1; echo = 8'hAA; a41_ones = 0; a41_seen = 0;
      frames.delete(); rq.delete(); fc = 0; ndummy = 0; ngap = 0;
      force_lat = 3;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!(frames.size() == 1 && fc >= 2) && cyc < 5000) begin @(negedge clk); cyc++; end
      chk("rstmid.reach_cmd8", frames.size() == 1 && fc >= 2, 1);
      cyc = 0;
      while (spi_req !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
      chk("rstmid.req_seen", spi_req, 1);
      #1 resetn = 1'b0; stale = 1'b1;
      #1;
      chk("rstmid.busy", busy, 0);       chk("rstmid.cs_n", cs_n, 1);
      chk("rstmid.spi_req", spi_req, 0); chk("rstmid.spi_tx", spi_tx, 8'hFF);
      chk("rstmid.slow_clk", slow_clk, 1);
      chk("rstmid.flags", {done, error, err_code, ccs}, 0);
      @(negedge clk); @(negedge clk);
      resetn = 1'b1;
      force_lat = -1;
      nr = nreq;
      repeat (10) @(negedge clk);
      chk("rstmid.late_ack_sent", pend, 0);
      chk("rstmid.no_req", nreq - nr, 0);
      chk("rstmid.idle", busy, 0);

      run_case("midstart", -1, 8'hAA, 1, 32'hC0FF8000, 1);
      run_case("rerun", -1, 8'hAA, 0, 32'h80FF8000, 0);
      run_case("mute8", 8, 8'hAA, 0, 32'hC0FF8000, 0);
      run_case("mute55", 55, 8'hAA, 0, 32'hC0FF8000, 0);
      run_case("mute41", 41, 8'hAA, 1, 32'hC0FF8000, 0);
      run_case("mute58", 58, 8'hAA, 0, 32'hC0FF8000, 0);

      for (int i = 0; i < 8; i++) begin
         r = int'($urandom_range(0, 9));
         run_case($sformatf("rnd%0d", i),
                  (r == 0) ? 0 : (r == 1) ? 8 : (r == 2) ? 55 : (r == 3) ? 41 : (r == 4) ? 58 : -1,
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hAA,
                  int'($urandom_range(0, 5)), $urandom, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sd_spi_seq.md
Name: sd_spi_seq

Overview:
- Controller that sequences the SoC's byte-level SPI master through the SD-card SPI-mode power-up and initialisation: dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
- Sits between the boot logic or CPU MMIO and the SPI master.
- Owns chip-select and the slow/fast SPI-clock select until initialisation completes.
- Reports success, card capacity class (CCS), or an error code.

Parameters:
- INIT_BYTES, 10, number of 0xFF bytes sent with cs_n high before CMD0 (10 bytes = 80 SPI clocks).
- RESP_TIMEOUT, 8, maximum 0xFF poll bytes after a command frame while waiting for R1 (R1 has bit7 = 0).
- ACMD41_RETRIES, 1000, maximum CMD55+ACMD41 iterations before failure; 16-bit counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins initialisation when not busy.
- busy  out  1  high from the cycle after an accepted start until done or error is asserted.
- done  out  1  sticky; high after successful initialisation; cleared by an accepted start.
- error  out  1  sticky; high after a failure; cleared by an accepted start.
- err_code  out  3  failure cause, valid while error is high.
- ccs  out  1  card capacity status from OCR bit 30; valid while done is high.
- slow_clk  out  1  high selects the ≤400 kHz SPI divider in the master.
- spi_req  out  1  single-cycle pulse; requests one byte exchange.
- spi_tx  out  8  byte to send; held stable from spi_req until spi_ack.
- spi_ack  in  1  single-cycle pulse from the master; exchange complete.
- spi_rx  in  8  received byte, valid in the spi_ack cycle.
- cs_n  out  1  SD chip select, active low.

Behaviour:
Reset values:
- busy=0, done=0, error=0, err_code=0, ccs=0, slow_clk=1, spi_req=0, spi_tx=8'hFF, cs_n=1.
- State IDLE; all counters 0.

Start handling:
- start is accepted only in IDLE, DONE or FAIL; it clears done, error and ccs, and sets slow_clk=1.
- start while busy is ignored.

Byte exchanges:
- At most one byte is outstanding at a time.
- The next spi_req is issued no earlier than the cycle after spi_ack.
- spi_ack with no request outstanding is ignored.

States:
- DUMMY: cs_n=1; send INIT_BYTES × 0xFF.
- CMD0: frame 40 00 00 00 00 95; R1 must equal 8'h01, otherwise err_code=1.
- CMD8: frame 48 00 00 01 AA 87; R1 must equal 01, then read 4 bytes. Byte3[3:0] must be 4'h1 and byte4 must be 8'hAA, otherwise err_code=2.
- C55: frame 77 00 00 00 00 01; any R1 with bit7=0 is accepted.
- A41: frame 69 40 00 00 00 01.
  - R1=00 → go to CMD58.
  - R1=01 → increment retry count and go back to C55.
  - Count reaching ACMD41_RETRIES, or any other R1 value → err_code=3.
- CMD58: frame 7A 00 00 00 00 FD; R1 must equal 00, then read 4 OCR bytes. ccs = OCR byte1 bit6 (OCR[30]). Otherwise err_code=4.
- DONE: done=1, slow_clk=0, cs_n=1, busy=0.
- FAIL: error=1, slow_clk stays 1, cs_n=1, busy=0.

Per-command transfer:
- cs_n=0; send 6 frame bytes (rx ignored).
- Poll with 0xFF until rx[7]==0, up to RESP_TIMEOUT polls. Timeout → the current command's err_code, and err_code=5 if the command is C55.
- Read the trailing response bytes.
- Raise cs_n, then send one 0xFF gap byte with cs_n=1.
- A failure also raises cs_n and sends the same gap byte before FAIL.

Reset mid-operation:
- An asynchronous resetn drop returns every output to its reset value immediately.
- An outstanding spi_ack arriving after reset is ignored.

Decomposition:
- Shared package sd_pkg:
  - command index constants (0, 8, 41, 55, 58) and CRC constants (95, 87, 01, FD);
  - err_code values 1–5;
  - sequencer state enum.
- One sub-module, sd_cmd_xfer, which handles the per-command transfer:
  - inputs: 6-byte frame, extra-byte count (0 or 4), and a go pulse;
  - drives the spi_req/spi_ack handshake and cs_n;
  - returns r1, a 32-bit trailing word, and either a done pulse or a timeout pulse.
- sd_spi_seq keeps the outer FSM, the retry counter and the status flags.

Test Plan:
- Card model accepts all commands; ACMD41 returns 01 twice then 00; OCR=C0FF8000. Required: 10 dummy bytes with cs_n=1, then the correct frames in order, then done=1, ccs=1, slow_clk=0, error=0. Exactly 3 C55/A41 pairs.
- Card model never drives MISO (rx=FF): after CMD0 plus 8 polls, error=1, err_code=1, cs_n=1, busy=0.
- CMD8 echo byte returns 8'hA5: error=1, err_code=2, and no C55 frame is sent.
- ACMD41_RETRIES=4 with ACMD41 always returning 01: exactly 4 A41 frames are sent, then error=1, err_code=3.
- resetn pulsed low during the CMD8 frame: outputs return to reset values in the same cycle. A following start replays the sequence from DUMMY, and a late spi_ack is ignored.
- start pulsed while busy: no effect on the sequence. start after done: done clears and the sequence reruns; OCR=80FF8000 gives ccs=0.
